// File: rtl/ccu_ctrl_mu_arbiter.sv
// Round-robin arbiter feeding a single registered memory-unit slot, with write-back credit limiting.
// Define CCU_CTRL_MU_ARBITER_PERF_EN to build the memory-unit stall counter.

package ccu_ctrl_mu_arbiter_pkg;
  typedef enum logic [2:0] {
    SEND_AXI_REQ_R,
    SEND_AXI_REQ_W,
    SEND_AXI_REQ_WRITE_BACK_R,
    SEND_AXI_REQ_WRITE_BACK_W
  } mu_op_e;
endpackage

module ccu_ctrl_mu_arbiter
  import ccu_ctrl_mu_arbiter_pkg::*;
#(
  parameter int unsigned NoReq            = 2,
  parameter int unsigned MaxWbOutstanding = 4,
  parameter int unsigned NoMstPorts       = 4,
  parameter type         slv_req_t        = logic,
  localparam int unsigned IdxBits         = $clog2(NoReq),
  localparam int unsigned MstIdxBits      = $clog2(NoMstPorts),
  localparam int unsigned CntBits         = $clog2(MaxWbOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NoReq-1:0]      req_valid_i,
  output logic [NoReq-1:0]      req_ready_o,
  input  mu_op_e                req_op_i              [NoReq],
  input  slv_req_t              req_holder_i          [NoReq],
  input  logic [MstIdxBits-1:0] req_first_responder_i [NoReq],
  output logic                  mu_valid_o,
  input  logic                  mu_ready_i,
  output mu_op_e                mu_op_o,
  output slv_req_t              mu_holder_o,
  output logic [MstIdxBits-1:0] mu_first_responder_o,
  output logic [IdxBits-1:0]    mu_grant_idx_o,
  input  logic                  wb_done_i,
  output logic [CntBits-1:0]    wb_outstanding_o,
  output logic                  wb_underflow_o,
  output logic [31:0]           stall_cnt_o
);

  typedef enum logic {SlotEmpty, SlotFull} slot_e;

  slot_e                 slot_q, slot_d;
  mu_op_e                op_q, op_d;
  slv_req_t              holder_q, holder_d;
  logic [MstIdxBits-1:0] fr_q, fr_d;
  logic [IdxBits-1:0]    idx_q, idx_d;
  logic [IdxBits-1:0]    rr_q, rr_d;
  logic [CntBits-1:0]    wb_cnt_q, wb_cnt_d;
  logic                  underflow_q, underflow_d;

  logic [NoReq-1:0]      eligible;
  logic                  wb_at_limit;
  logic                  can_load;
  logic                  grant_vld;
  logic [IdxBits-1:0]    grant_idx;
  logic                  wb_accept;

  function automatic logic is_wb(mu_op_e op);
    return (op == SEND_AXI_REQ_WRITE_BACK_R) || (op == SEND_AXI_REQ_WRITE_BACK_W);
  endfunction

  assign wb_at_limit = (wb_cnt_q == CntBits'(MaxWbOutstanding));
  assign can_load    = (slot_q == SlotEmpty) || mu_ready_i;

  // Arbitration looks only at valid/op so ready never depends on payload.
  always_comb begin
    eligible    = '0;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    req_ready_o = '0;
    for (int unsigned i = 0; i < NoReq; i++) begin
      eligible[i] = req_valid_i[i] && !(is_wb(req_op_i[i]) && wb_at_limit);
    end
    if (can_load) begin
      for (int unsigned k = 0; k < NoReq; k++) begin
        automatic int unsigned     cand     = int'(rr_q) + k;
        automatic logic [IdxBits-1:0] cand_idx;
        if (cand >= NoReq) cand = cand - NoReq;
        cand_idx = IdxBits'(cand);
        if (!grant_vld && eligible[cand_idx]) begin
          grant_vld = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
    if (grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  assign wb_accept = grant_vld && is_wb(req_op_i[grant_idx]);

  always_comb begin
    slot_d   = slot_q;
    op_d     = op_q;
    holder_d = holder_q;
    fr_d     = fr_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    if (grant_vld) begin
      automatic int unsigned nxt = int'(grant_idx) + 1;
      if (nxt >= NoReq) nxt = 0;
      slot_d   = SlotFull;
      op_d     = req_op_i[grant_idx];
      holder_d = req_holder_i[grant_idx];
      fr_d     = req_first_responder_i[grant_idx];
      idx_d    = grant_idx;
      rr_d     = IdxBits'(nxt);
    end else if ((slot_q == SlotFull) && mu_ready_i) begin
      slot_d = SlotEmpty;
    end
  end

  // Simultaneous accept and done cancel; a done with nothing outstanding only flags underflow.
  always_comb begin
    wb_cnt_d    = wb_cnt_q;
    underflow_d = underflow_q;
    unique case ({wb_accept, wb_done_i})
      2'b10: wb_cnt_d = wb_cnt_q + CntBits'(1);
      2'b01: begin
        if (wb_cnt_q != '0) wb_cnt_d = wb_cnt_q - CntBits'(1);
        else                underflow_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q      <= SlotEmpty;
      op_q        <= SEND_AXI_REQ_R;
      holder_q    <= '0;
      fr_q        <= '0;
      idx_q       <= '0;
      rr_q        <= '0;
      wb_cnt_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      op_q        <= op_d;
      holder_q    <= holder_d;
      fr_q        <= fr_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      wb_cnt_q    <= wb_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign mu_valid_o           = (slot_q == SlotFull);
  assign mu_op_o              = op_q;
  assign mu_holder_o          = holder_q;
  assign mu_first_responder_o = fr_q;
  assign mu_grant_idx_o       = idx_q;
  assign wb_outstanding_o     = wb_cnt_q;
  assign wb_underflow_o       = underflow_q;

`ifdef CCU_CTRL_MU_ARBITER_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((slot_q == SlotFull) && !mu_ready_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ccu_ctrl_mu_arbiter.sv
// Directed self-checking bench for ccu_ctrl_mu_arbiter (NoReq=2, MaxWbOutstanding=4).
module tb_ccu_ctrl_mu_arbiter;
  import ccu_ctrl_mu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  mu_op_e     req_op     [2];
  logic       req_holder [2];
  logic [1:0] req_fr     [2];
  logic       mu_valid;
  logic       mu_ready;
  mu_op_e     mu_op;
  logic       mu_holder;
  logic [1:0] mu_fr;
  logic       mu_idx;
  logic       wb_done;
  logic [2:0] wb_out;
  logic       wb_uf;
  logic [31:0] stall_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef CCU_CTRL_MU_ARBITER_PERF_EN
  localparam logic [31:0] ExpStall = 32'd5;
`else
  localparam logic [31:0] ExpStall = 32'd0;
`endif

  always #5 clk = ~clk;

  ccu_ctrl_mu_arbiter #(
    .NoReq            (2),
    .MaxWbOutstanding (4),
    .NoMstPorts       (4),
    .slv_req_t        (logic)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .req_op_i              (req_op),
    .req_holder_i          (req_holder),
    .req_first_responder_i (req_fr),
    .mu_valid_o            (mu_valid),
    .mu_ready_i            (mu_ready),
    .mu_op_o               (mu_op),
    .mu_holder_o           (mu_holder),
    .mu_first_responder_o  (mu_fr),
    .mu_grant_idx_o        (mu_idx),
    .wb_done_i             (wb_done),
    .wb_outstanding_o      (wb_out),
    .wb_underflow_o        (wb_uf),
    .stall_cnt_o           (stall_cnt)
  );

  task automatic drive_idle();
    req_valid     = '0;
    req_op[0]     = SEND_AXI_REQ_R;
    req_op[1]     = SEND_AXI_REQ_R;
    req_holder[0] = 1'b0;
    req_holder[1] = 1'b0;
    req_fr[0]     = 2'd0;
    req_fr[1]     = 2'd0;
    mu_ready      = 1'b0;
    wb_done       = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #1;
    tests_run++; if (mu_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", mu_valid); end
    tests_run++; if (mu_idx !== 1'b0) begin tests_failed++; $display("FAIL reset_idx got=%b exp=0", mu_idx); end
    tests_run++; if (mu_holder !== 1'b0 || mu_fr !== 2'd0 || mu_op !== SEND_AXI_REQ_R) begin tests_failed++; $display("FAIL reset_payload got=%b/%0d/%0d exp=0/0/0", mu_holder, mu_fr, mu_op); end
    tests_run++; if (wb_out !== 3'd0 || wb_uf !== 1'b0) begin tests_failed++; $display("FAIL reset_wb got=%0d/%b exp=0/0", wb_out, wb_uf); end
    tests_run++; if (stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    logic       exp_idx;
    apply_reset();
    mu_ready      = 1'b1;
    req_holder[0] = 1'b0;
    req_holder[1] = 1'b1;
    req_fr[0]     = 2'd2;
    req_fr[1]     = 2'd3;
    req_valid     = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_idx = (k % 2 == 1);
      exp_rdy = exp_idx ? 2'b10 : 2'b01;
      #1;
      tests_run++; if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      @(posedge clk); #1;
      tests_run++; if (mu_valid !== 1'b1 || mu_idx !== exp_idx) begin tests_failed++; $display("FAIL rr_grant k=%0d got=%b/%b exp=1/%b", k, mu_valid, mu_idx, exp_idx); end
      tests_run++; if (mu_holder !== exp_idx || mu_fr !== {1'b1, exp_idx}) begin tests_failed++; $display("FAIL rr_payload k=%0d got=%b/%0d exp=%b/%0d", k, mu_holder, mu_fr, exp_idx, {1'b1, exp_idx}); end
    end
    req_valid = 2'b00;
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL rr_idle_ready got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (mu_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_drain got=%b exp=0", mu_valid); end
  endtask

  task automatic test_stall();
    apply_reset();
    req_holder[0] = 1'b1;
    req_fr[0]     = 2'd1;
    req_valid     = 2'b01;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL stall_first_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (mu_valid !== 1'b1 || mu_holder !== 1'b1) begin tests_failed++; $display("FAIL stall_load got=%b/%b exp=1/1", mu_valid, mu_holder); end
    req_holder[0] = 1'b0;
    req_fr[0]     = 2'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL stall_ready k=%0d got=%b exp=00", k, req_ready); end
      @(posedge clk); #1;
      tests_run++; if (mu_valid !== 1'b1 || mu_holder !== 1'b1 || mu_fr !== 2'd1) begin tests_failed++; $display("FAIL stall_hold k=%0d got=%b/%b/%0d exp=1/1/1", k, mu_valid, mu_holder, mu_fr); end
    end
    tests_run++; if (stall_cnt !== ExpStall) begin tests_failed++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, ExpStall); end
    req_valid = 2'b00;
    mu_ready  = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (mu_valid !== 1'b0 || stall_cnt !== ExpStall) begin tests_failed++; $display("FAIL stall_release got=%b/%0d exp=0/%0d", mu_valid, stall_cnt, ExpStall); end
  endtask

  task automatic test_wb_limit();
    apply_reset();
    mu_ready  = 1'b1;
    req_op[0] = SEND_AXI_REQ_WRITE_BACK_W;
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL wb_ready k=%0d got=%b exp=01", k, req_ready); end
      @(posedge clk); #1;
      tests_run++; if (wb_out !== 3'(k + 1)) begin tests_failed++; $display("FAIL wb_count k=%0d got=%0d exp=%0d", k, wb_out, k + 1); end
    end
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL wb_fifth_blocked got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (mu_valid !== 1'b0 || wb_out !== 3'd4) begin tests_failed++; $display("FAIL wb_at_limit got=%b/%0d exp=0/4", mu_valid, wb_out); end
    wb_done = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL wb_done_cycle_ready got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    wb_done = 1'b0;
    tests_run++; if (wb_out !== 3'd3) begin tests_failed++; $display("FAIL wb_after_done got=%0d exp=3", wb_out); end
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL wb_fifth_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (wb_out !== 3'd4 || mu_valid !== 1'b1 || mu_op !== SEND_AXI_REQ_WRITE_BACK_W) begin tests_failed++; $display("FAIL wb_fifth_accept got=%0d/%b/%0d exp=4/1/%0d", wb_out, mu_valid, mu_op, SEND_AXI_REQ_WRITE_BACK_W); end
    req_valid = 2'b00;
  endtask

  task automatic test_wb_skip();
    apply_reset();
    mu_ready  = 1'b1;
    req_op[1] = SEND_AXI_REQ_WRITE_BACK_R;
    req_valid = 2'b10;
    repeat (4) begin @(posedge clk); #1; end
    tests_run++; if (wb_out !== 3'd4) begin tests_failed++; $display("FAIL skip_fill got=%0d exp=4", wb_out); end
    req_op[0] = SEND_AXI_REQ_WRITE_BACK_R;
    req_op[1] = SEND_AXI_REQ_W;
    req_valid = 2'b11;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL skip_ready got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (mu_idx !== 1'b1 || mu_op !== SEND_AXI_REQ_W || wb_out !== 3'd4) begin tests_failed++; $display("FAIL skip_grant got=%b/%0d/%0d exp=1/%0d/4", mu_idx, mu_op, wb_out, SEND_AXI_REQ_W); end
    req_valid = 2'b00;
  endtask

  task automatic test_wb_same_cycle();
    apply_reset();
    mu_ready  = 1'b1;
    req_op[0] = SEND_AXI_REQ_WRITE_BACK_R;
    req_valid = 2'b01;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++; if (wb_out !== 3'd2) begin tests_failed++; $display("FAIL same_fill got=%0d exp=2", wb_out); end
    wb_done = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL same_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (wb_out !== 3'd2) begin tests_failed++; $display("FAIL same_cancel got=%0d exp=2", wb_out); end
    req_valid = 2'b00;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++; if (wb_out !== 3'd0 || wb_uf !== 1'b0) begin tests_failed++; $display("FAIL same_drain got=%0d/%b exp=0/0", wb_out, wb_uf); end
    @(posedge clk); #1;
    wb_done = 1'b0;
    tests_run++; if (wb_out !== 3'd0 || wb_uf !== 1'b1) begin tests_failed++; $display("FAIL underflow got=%0d/%b exp=0/1", wb_out, wb_uf); end
    @(posedge clk); #1;
    tests_run++; if (wb_uf !== 1'b1) begin tests_failed++; $display("FAIL underflow_sticky got=%b exp=1", wb_uf); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 2'b01;
    @(posedge clk); #1;
    tests_run++; if (mu_valid !== 1'b1 || mu_idx !== 1'b0) begin tests_failed++; $display("FAIL mid_load got=%b/%b exp=1/0", mu_valid, mu_idx); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (mu_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_valid got=%b exp=0", mu_valid); end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 2'b11;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_rr_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (mu_valid !== 1'b1 || mu_idx !== 1'b0) begin tests_failed++; $display("FAIL mid_rr_grant got=%b/%b exp=1/0", mu_valid, mu_idx); end
    req_valid = 2'b00;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_stall();
    test_wb_limit();
    test_wb_skip();
    test_wb_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
